// File: rtl/bc_pkg.sv
// Shared types and constants for the bulls-and-cows game controller.
package bc_pkg;

    localparam int unsigned DIGIT_W    = 3;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned CODE_W     = DIGIT_W * NUM_DIGITS;

    // Codes are visible on the state port, so they are pinned explicitly.
    typedef enum logic [2:0] {
        WAIT_SECRET = 3'd0,
        CHK_SECRET  = 3'd1,
        WAIT_GUESS  = 3'd2,
        CHK_GUESS   = 3'd3,
        SCORE       = 3'd4,
        WIN         = 3'd5,
        LOSE        = 3'd6
    } bc_state_e;

endpackage

// File: rtl/bc_scorer.sv
// Combinational bulls/cows counter plus repeated-digit check on the guess.
module bc_scorer
    import bc_pkg::*;
(
    input  logic [CODE_W-1:0] guess,
    input  logic [CODE_W-1:0] secret,
    output logic [2:0]        bulls,
    output logic [2:0]        cows,
    output logic              distinct
);

    // Pairwise digit comparison; cows are only meaningful when both codes are distinct.
    always_comb begin
        bulls    = '0;
        cows     = '0;
        distinct = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (guess[i*DIGIT_W +: DIGIT_W] == secret[i*DIGIT_W +: DIGIT_W]) begin
                bulls = bulls + 3'd1;
            end
            for (int j = 0; j < NUM_DIGITS; j++) begin
                if (j != i) begin
                    if (guess[i*DIGIT_W +: DIGIT_W] == secret[j*DIGIT_W +: DIGIT_W]) begin
                        cows = cows + 3'd1;
                    end
                    if (j > i && guess[i*DIGIT_W +: DIGIT_W] == guess[j*DIGIT_W +: DIGIT_W]) begin
                        distinct = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/bc_game_ctrl.sv
// Bulls-and-cows game controller: secret entry, guess scoring, win/lose.
// Optional attempt limit (LOSE state) is compiled in with BC_ATTEMPT_LIMIT_EN.
module bc_game_ctrl
    import bc_pkg::*;
#(
    parameter int unsigned MAX_ATTEMPTS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] digits,
    input  logic              save,
    output logic [2:0]        state,
    output logic [2:0]        bulls,
    output logic [2:0]        cows,
    output logic [3:0]        attempts,
    output logic              result_valid,
    output logic              err,
    output logic              win,
    output logic              lose
);

    if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 15) begin : g_bad_max_attempts
        $error("MAX_ATTEMPTS must be in 1..15");
    end

    bc_state_e         state_q, state_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CODE_W-1:0] secret_q, secret_d;
    logic [2:0]        bulls_q, bulls_d;
    logic [2:0]        cows_q, cows_d;
    logic [3:0]        attempts_q, attempts_d;
    logic              rv_q, rv_d;
    logic              err_q, err_d;

    logic [2:0]        sc_bulls;
    logic [2:0]        sc_cows;
    logic              sc_distinct;
    logic [3:0]        attempts_inc;
    logic              limit_hit;

    bc_scorer u_scorer (
        .guess    (cand_q),
        .secret   (secret_q),
        .bulls    (sc_bulls),
        .cows     (sc_cows),
        .distinct (sc_distinct)
    );

    // Saturating increment: attempts sticks at 15.
    assign attempts_inc = (attempts_q == 4'hF) ? 4'hF : attempts_q + 4'd1;

`ifdef BC_ATTEMPT_LIMIT_EN
    assign limit_hit = (attempts_inc == 4'(MAX_ATTEMPTS));
`else
    assign limit_hit = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_SECRET;
            cand_q     <= '0;
            secret_q   <= '0;
            bulls_q    <= '0;
            cows_q     <= '0;
            attempts_q <= '0;
            rv_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            secret_q   <= secret_d;
            bulls_q    <= bulls_d;
            cows_q     <= cows_d;
            attempts_q <= attempts_d;
            rv_q       <= rv_d;
            err_q      <= err_d;
        end
    end

    // Next-state and datapath updates; save is ignored outside the WAIT/end states.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        secret_d   = secret_q;
        bulls_d    = bulls_q;
        cows_d     = cows_q;
        attempts_d = attempts_q;
        rv_d       = 1'b0;
        err_d      = err_q;

        unique case (state_q)
            WAIT_SECRET: begin
                if (save) begin
                    cand_d  = digits;
                    err_d   = 1'b0;
                    state_d = CHK_SECRET;
                end
            end
            CHK_SECRET: begin
                if (sc_distinct) begin
                    secret_d = cand_q;
                    state_d  = WAIT_GUESS;
                end else begin
                    err_d   = 1'b1;
                    state_d = WAIT_SECRET;
                end
            end
            WAIT_GUESS: begin
                if (save) begin
                    cand_d  = digits;
                    err_d   = 1'b0;
                    state_d = CHK_GUESS;
                end
            end
            CHK_GUESS: begin
                if (sc_distinct) begin
                    state_d = SCORE;
                end else begin
                    err_d   = 1'b1;
                    state_d = WAIT_GUESS;
                end
            end
            SCORE: begin
                bulls_d    = sc_bulls;
                cows_d     = sc_cows;
                rv_d       = 1'b1;
                attempts_d = attempts_inc;
                if (sc_bulls == 3'(NUM_DIGITS)) begin
                    state_d = WIN;
                end else if (limit_hit) begin
                    state_d = LOSE;
                end else begin
                    state_d = WAIT_GUESS;
                end
            end
            WIN, LOSE: begin
                if (save) begin
                    attempts_d = '0;
                    bulls_d    = '0;
                    cows_d     = '0;
                    err_d      = 1'b0;
                    state_d    = WAIT_SECRET;
                end
            end
            default: state_d = WAIT_SECRET;
        endcase
    end

    assign state        = state_q;
    assign bulls        = bulls_q;
    assign cows         = cows_q;
    assign attempts     = attempts_q;
    assign result_valid = rv_q;
    assign err          = err_q;
    assign win          = (state_q == WIN);
    assign lose         = (state_q == LOSE);

endmodule

// File: tb/tb_bc_game_ctrl.sv
// Scoreboard bench for bc_game_ctrl: driver pushes expected results, monitor pops on result_valid.
module tb_bc_game_ctrl;

    localparam int MAXA = 10;
`ifdef BC_ATTEMPT_LIMIT_EN
    localparam bit LIMIT_ON = 1'b1;
`else
    localparam bit LIMIT_ON = 1'b0;
`endif
    // Externally visible state codes.
    localparam int S_WAIT_SECRET = 0;
    localparam int S_WAIT_GUESS  = 2;
    localparam int S_SCORE       = 4;
    localparam int S_WIN         = 5;
    localparam int S_LOSE        = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] digits = '0;
    logic        save = 1'b0;
    logic [2:0]  state;
    logic [2:0]  bulls;
    logic [2:0]  cows;
    logic [3:0]  attempts;
    logic        result_valid;
    logic        err;
    logic        win;
    logic        lose;

    bc_game_ctrl #(.MAX_ATTEMPTS(MAXA)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .digits       (digits),
        .save         (save),
        .state        (state),
        .bulls        (bulls),
        .cows         (cows),
        .attempts     (attempts),
        .result_valid (result_valid),
        .err          (err),
        .win          (win),
        .lose         (lose)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int b;
        int c;
        int att;
        int cyc;
        int w;
        int l;
    } exp_t;
    exp_t sb[$];

    // Reference game state.
    logic [11:0] m_secret;
    int          m_att;
    bit          m_err;
    bit          m_over;
    bit          m_in_guess;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dig(input logic [11:0] x, input int i);
        return int'((x >> (3 * i)) & 12'h7);
    endfunction

    function automatic bit is_distinct(input logic [11:0] x);
        bit seen[8];
        for (int k = 0; k < 8; k++) seen[k] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (seen[dig(x, i)]) return 1'b0;
            seen[dig(x, i)] = 1'b1;
        end
        return 1'b1;
    endfunction

    // Bulls = same position; cows = shared digits minus bulls.
    task automatic ref_score(input logic [11:0] s, input logic [11:0] g, output int b, output int c);
        int common;
        b = 0;
        common = 0;
        for (int i = 0; i < 4; i++) begin
            if (dig(s, i) == dig(g, i)) b++;
            for (int j = 0; j < 4; j++) if (dig(g, i) == dig(s, j)) common++;
        end
        c = common - b;
    endtask

    function automatic logic [11:0] rand_distinct();
        int pool[8];
        logic [11:0] r;
        int t;
        int k;
        for (int i = 0; i < 8; i++) pool[i] = i;
        for (int i = 7; i > 0; i--) begin
            k = int'($urandom_range(0, i));
            t = pool[i];
            pool[i] = pool[k];
            pool[k] = t;
        end
        r = '0;
        for (int i = 0; i < 4; i++) r = r | (12'(pool[i]) << (3 * i));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random save pulse on a cycle where the DUT must ignore it.
    task automatic noise_tick();
        if ($urandom_range(0, 1) == 1) begin
            digits = 12'($urandom);
            save   = 1'b1;
        end
        tick();
        save = 1'b0;
    endtask

    task automatic press(input logic [11:0] d, output int c);
        digits = d;
        save   = 1'b1;
        c      = cyc;
        tick();
        save   = 1'b0;
        digits = 12'($urandom);
    endtask

    task automatic do_secret(input logic [11:0] d);
        int c;
        press(d, c);
        noise_tick();
        if (is_distinct(d)) begin
            m_secret   = d;
            m_err      = 1'b0;
            m_in_guess = 1'b1;
            chk("secret_state", int'(state), S_WAIT_GUESS);
        end else begin
            m_err = 1'b1;
            chk("secret_state", int'(state), S_WAIT_SECRET);
        end
        chk("secret_err", int'(err), int'(m_err));
        chk("secret_att", int'(attempts), 0);
    endtask

    task automatic do_guess(input logic [11:0] g);
        int c;
        int b;
        int cw;
        exp_t e;
        press(g, c);
        if (!is_distinct(g)) begin
            noise_tick();
            m_err = 1'b1;
            chk("dup_state", int'(state), S_WAIT_GUESS);
            chk("dup_err", int'(err), 1);
            chk("dup_att", int'(attempts), m_att);
            return;
        end
        m_err = 1'b0;
        ref_score(m_secret, g, b, cw);
        m_att = (m_att >= 15) ? 15 : m_att + 1;
        e.b   = b;
        e.c   = cw;
        e.att = m_att;
        e.cyc = c + 3;
        e.w   = (b == 4) ? 1 : 0;
        e.l   = (b != 4 && LIMIT_ON && m_att == MAXA) ? 1 : 0;
        sb.push_back(e);
        noise_tick();
        noise_tick();
        if (e.w == 1) chk("guess_state", int'(state), S_WIN);
        else if (e.l == 1) chk("guess_state", int'(state), S_LOSE);
        else chk("guess_state", int'(state), S_WAIT_GUESS);
        chk("guess_err", int'(err), 0);
        m_over = (e.w == 1) || (e.l == 1);
        @(negedge clk);
        #1;
        chk("rv_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic restart();
        int c;
        press(12'($urandom), c);
        chk("rst_state", int'(state), S_WAIT_SECRET);
        chk("rst_att", int'(attempts), 0);
        chk("rst_bulls", int'(bulls), 0);
        chk("rst_cows", int'(cows), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_winlose", int'({win, lose}), 0);
        m_att      = 0;
        m_err      = 1'b0;
        m_over     = 1'b0;
        m_in_guess = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, int'(state), S_WAIT_SECRET);
        chk({tag, "_bulls"}, int'(bulls), 0);
        chk({tag, "_cows"}, int'(cows), 0);
        chk({tag, "_att"}, int'(attempts), 0);
        chk({tag, "_rv"}, int'(result_valid), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_win"}, int'(win), 0);
        chk({tag, "_lose"}, int'(lose), 0);
    endtask

    // Monitor: every result_valid pulse must match the oldest expected score.
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (sb.size() == 0) begin
                chk("rv_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_bulls", int'(bulls), e.b);
                chk("mon_cows", int'(cows), e.c);
                chk("mon_att", int'(attempts), e.att);
                chk("mon_latency_cyc", cyc, e.cyc);
                chk("mon_win", int'(win), e.w);
                chk("mon_lose", int'(lose), e.l);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [11:0] g;
        int r;
        m_att = 0;
        m_err = 1'b0;
        m_over = 1'b0;
        m_in_guess = 1'b0;
        m_secret = '0;

        #3 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Exact-match win.
        do_secret(12'o0123);
        do_guess(12'o0123);
        restart();

        // Repeated-digit secret rejected, then accepted.
        do_secret(12'o0012);
        do_secret(12'o0765);
        do_guess(12'o0765);
        restart();

        // All cows, duplicate guess, then reset asserted while in SCORE.
        do_secret(12'o0123);
        do_guess(12'o3210);
        do_guess(12'o0112);
        press(12'o1023, c);
        tick();
        chk("pre_rst_state", int'(state), S_SCORE);
        rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        m_att = 0;
        m_err = 1'b0;
        m_over = 1'b0;
        m_in_guess = 1'b0;
        repeat (6) tick();
        chk_all_zero("post_rst");

        // Attempt limit / saturation with repeated wrong guesses.
        do_secret(12'o0123);
        for (int i = 0; i < (LIMIT_ON ? MAXA : 16); i++) do_guess(12'o4567);
        chk("limit_att", int'(attempts), LIMIT_ON ? MAXA : 15);
        chk("limit_lose", int'(lose), LIMIT_ON ? 1 : 0);
        if (!m_over) do_guess(m_secret);
        restart();

        // Random games.
        for (int gm = 0; gm < 25; gm++) begin
            do_secret(12'($urandom));
            if (!m_in_guess) do_secret(rand_distinct());
            for (int k = 0; k < 20 && !m_over; k++) begin
                r = int'($urandom_range(0, 99));
                if (r < 15) g = m_secret;
                else if (r < 35) g = 12'($urandom);
                else g = rand_distinct();
                do_guess(g);
            end
            if (!m_over) do_guess(m_secret);
            restart();
        end

        repeat (4) tick();
        chk("final_queue", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bc_game_ctrl.md
BC_GAME_CTRL -- requirements
Module: bc_game_ctrl

Interface
REQ-001 SHALL have parameter MAX_ATTEMPTS, default 10, meaning the number of scored guesses before a loss (range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port digits, input, 12 bits: four 3-bit octal digits, D0=[2:0], D1=[5:3], D2=[8:6], D3=[11:9].
REQ-005 SHALL have port save, input, 1 bit: one-cycle pulse from the edge detector; commits `digits`.
REQ-006 SHALL have port state, output, 3 bits: current FSM state code.
REQ-007 SHALL have port bulls, output, 3 bits: bulls count (0..4) of the last scored guess.
REQ-008 SHALL have port cows, output, 3 bits: cows count (0..4) of the last scored guess.
REQ-009 SHALL have port attempts, output, 4 bits: number of scored guesses this game.
REQ-010 SHALL have port result_valid, output, 1 bit: one-cycle pulse when bulls/cows update.
REQ-011 SHALL have port err, output, 1 bit: last committed entry had repeated digits.
REQ-012 SHALL have ports win and lose, outputs, 1 bit each: game-end flags.

Function
REQ-013 SHALL implement FSM states WAIT_SECRET, CHK_SECRET, WAIT_GUESS, CHK_GUESS, SCORE, WIN, LOSE.
REQ-014 SHALL, in WAIT_SECRET, on save: latch digits into candidate register, clear err, go to CHK_SECRET.
REQ-015 SHALL, in CHK_SECRET (1 cycle): if all four digits are distinct, copy candidate to secret and go to WAIT_GUESS; else set err and return to WAIT_SECRET.
REQ-016 SHALL, in WAIT_GUESS, on save: latch digits into candidate, clear err, go to CHK_GUESS.
REQ-017 SHALL, in CHK_GUESS (1 cycle): if digits are distinct, go to SCORE; else set err, return to WAIT_GUESS, attempts unchanged.
REQ-018 SHALL, in SCORE (1 cycle): register bulls = count of equal positions; register cows = count of digits present in secret at a different position; pulse result_valid; increment attempts.
REQ-019 SHALL make result_valid high on the cycle after SCORE, with bulls/cows valid on that same cycle; latency from save to result_valid is 3 clocks.
REQ-020 SHALL, leaving SCORE: go to WIN if bulls==4; else go to LOSE if the limit applies and attempts reaches MAX_ATTEMPTS; else go to WAIT_GUESS.
REQ-021 SHALL hold win=1 in WIN and lose=1 in LOSE, keeping bulls, cows and attempts frozen.
REQ-022 SHALL, in WIN or LOSE, on save: clear attempts, bulls, cows and err, and go to WAIT_SECRET; the digits are not latched.
REQ-023 SHALL ignore save in CHK_SECRET, CHK_GUESS and SCORE.
REQ-024 SHALL saturate attempts at 15 and never wrap.
REQ-025 SHALL never expose the secret on any output.

Reset
REQ-026 SHALL, while rst_n=0, force state=WAIT_SECRET; bulls, cows, attempts, secret and candidate to 0; result_valid, err, win and lose to 0.
REQ-027 SHALL abandon any game in progress on reset assertion mid-game, with no residual pulse after release.

Configuration
REQ-028 SHALL compile the attempt limit only when BC_ATTEMPT_LIMIT_EN is defined; then LOSE is reachable per REQ-020.
REQ-029 SHALL, without BC_ATTEMPT_LIMIT_EN, never enter LOSE and hold lose=0; attempts saturates per REQ-024.

Structure
REQ-030 SHALL place the state enum with its codes (WAIT_SECRET=0 .. LOSE=6), the digit-width constant (3) and the digit-count constant (4) in the shared package bc_pkg.
REQ-031 SHALL implement bulls/cows counting and the distinct-digit check in a combinational sub-module bc_scorer, instantiated once.

Verification
REQ-032 SHALL cover secret 0o0123 then guess 0o0123 -> bulls=4, cows=0, result_valid 3 clocks after save, win=1, attempts=1.
REQ-033 SHALL cover secret 0o0123 then guess 0o3210 -> bulls=0, cows=4, state back to WAIT_GUESS, attempts=1.
REQ-034 SHALL cover secret 0o0012 -> err=1, state=WAIT_SECRET; then 0o0765 -> err=0, state=WAIT_GUESS.
REQ-035 SHALL cover, with BC_ATTEMPT_LIMIT_EN, 10 wrong guesses 0o4567 against secret 0o0123 -> lose=1 after the 10th, attempts=10; without the macro, 16 wrong guesses -> attempts=15, lose=0.
REQ-036 SHALL cover rst_n pulled low in SCORE -> all outputs 0 asynchronously, state=WAIT_SECRET, no result_valid after release.
